// File: rtl/mod_seq_pkg.sv
// Shared types and widths for the modulo count sequencer.
package mod_seq_pkg;
  localparam int CNT_W         = 4;
  localparam int WRAP_W        = 8;
  localparam int DEFAULT_MOD_P = 14;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  // A modulus of 0 or 1 cannot form a period, so fall back to the default.
  function automatic logic [CNT_W-1:0] sanitize_mod(input logic [CNT_W-1:0] m,
                                                    input logic [CNT_W-1:0] dflt);
    return (m <= CNT_W'(1)) ? dflt : m;
  endfunction
endpackage

// File: rtl/mod_counter_core.sv
// Modulo-N count register: clr loads the start value, en advances one step.
// Next-edge update, no backpressure; wrap flags the last value of the period.
module mod_counter_core
  import mod_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic [CNT_W-1:0] mod,
  output logic [CNT_W-1:0] q,
  output logic             wrap
);
  logic [CNT_W-1:0] q_d, q_q, top_val;

  always_comb begin
    top_val = mod - CNT_W'(1);
    wrap    = dir ? (q_q == '0) : (q_q == top_val);
    q_d     = q_q;
    if (clr) begin
      q_d = dir ? top_val : '0;
    end else if (en) begin
      if (wrap) q_d = dir ? top_val : '0;
      else      q_d = dir ? (q_q - CNT_W'(1)) : (q_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/mod_count_seq.sv
// Start/stop/pause sequencer running a modulo counter for a set number of periods.
// Registered outputs, start-to-RUN one edge, no backpressure; COUNT_DOWN_EN adds a dir input.
module mod_count_seq
  import mod_seq_pkg::*;
#(
  parameter int DEFAULT_MOD = DEFAULT_MOD_P
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [CNT_W-1:0]  mod_val,
  input  logic [WRAP_W-1:0] wraps,
`ifdef COUNT_DOWN_EN
  input  logic              dir,
`endif
  output logic [CNT_W-1:0]  q,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              busy,
  output logic              done
);
  localparam logic [CNT_W-1:0] DFLT = CNT_W'(DEFAULT_MOD);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  mod_d, mod_q, mod_new, core_mod;
  logic [WRAP_W-1:0] wraps_d, wraps_q, wrap_cnt_d, wrap_cnt_q;
  logic              dir_d, dir_q, dir_in;
  logic              core_en, core_clr, core_dir, core_wrap, step;

`ifdef COUNT_DOWN_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mod_d      = mod_q;
    wraps_d    = wraps_q;
    wrap_cnt_d = wrap_cnt_q;
    dir_d      = dir_q;
    mod_new    = sanitize_mod(mod_val, DFLT);
    core_en    = 1'b0;
    core_clr   = 1'b0;
    core_mod   = mod_q;
    core_dir   = dir_q;
    step       = 1'b0;

    case (state_q)
      S_IDLE: begin
        core_clr = 1'b1;
        core_dir = 1'b0;
        if (start) begin
          state_d    = S_RUN;
          mod_d      = mod_new;
          wraps_d    = wraps;
          dir_d      = dir_in;
          wrap_cnt_d = '0;
          core_mod   = mod_new;
          core_dir   = dir_in;
        end
      end
      S_RUN: begin
        if (pause) state_d = S_PAUSE;
        else       step    = 1'b1;
      end
      S_PAUSE: begin
        if (!pause) begin
          state_d = S_RUN;
          step    = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        core_clr = 1'b1;
        core_dir = 1'b0;
      end
    endcase

    if (step) begin
      core_en = 1'b1;
      if (core_wrap) begin
        if ((wraps_q != '0) && ((wrap_cnt_q + WRAP_W'(1)) == wraps_q)) begin
          // Final period: park the count at zero regardless of direction.
          state_d    = S_DONE;
          wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
          core_en    = 1'b0;
          core_clr   = 1'b1;
          core_dir   = 1'b0;
        end else begin
          wrap_cnt_d = (wrap_cnt_q == '1) ? wrap_cnt_q : (wrap_cnt_q + WRAP_W'(1));
        end
      end
    end

    // stop wins over everything else, including a same-cycle finish.
    if (stop) begin
      state_d    = S_IDLE;
      mod_d      = mod_q;
      wraps_d    = wraps_q;
      dir_d      = dir_q;
      wrap_cnt_d = wrap_cnt_q;
      core_en    = 1'b0;
      core_clr   = 1'b1;
      core_dir   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mod_q      <= DFLT;
      wraps_q    <= '0;
      wrap_cnt_q <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mod_q      <= mod_d;
      wraps_q    <= wraps_d;
      wrap_cnt_q <= wrap_cnt_d;
      dir_q      <= dir_d;
    end
  end

  mod_counter_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (core_en),
    .clr   (core_clr),
    .dir   (core_dir),
    .mod   (core_mod),
    .q     (q),
    .wrap  (core_wrap)
  );

  assign tc       = (state_q == S_RUN) && (dir_q ? (q == '0) : (q == (mod_q - CNT_W'(1))));
  assign wrap_cnt = wrap_cnt_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done     = (state_q == S_DONE);
endmodule

// File: tb/tb_mod_count_seq.sv
// Directed bench for mod_count_seq: outputs are checked and inputs driven at the falling edge.
module tb_mod_count_seq;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, pause;
  logic [3:0] mod_val, q;
  logic [7:0] wraps, wrap_cnt;
  logic       tc, busy, done;
`ifdef COUNT_DOWN_EN
  logic       dir;
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_count_seq #(.DEFAULT_MOD(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .mod_val(mod_val), .wraps(wraps),
`ifdef COUNT_DOWN_EN
    .dir(dir),
`endif
    .q(q), .tc(tc), .wrap_cnt(wrap_cnt), .busy(busy), .done(done)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] eq, input logic etc,
                     input logic [7:0] ew, input logic eb, input logic ed);
    logic [14:0] obs, exp;
    obs = {q, tc, wrap_cnt, busy, done};
    exp = {eq, etc, ew, eb, ed};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed q=%0d tc=%b wrap_cnt=%0d busy=%b done=%b, expected q=%0d tc=%b wrap_cnt=%0d busy=%b done=%b",
             tag, q, tc, wrap_cnt, busy, done, eq, etc, ew, eb, ed);
    end
  endtask

  task automatic go(input logic [3:0] m, input logic [7:0] w);
    mod_val = m; wraps = w; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mod_val = 4'd0; wraps = 8'd0;
`ifdef COUNT_DOWN_EN
    dir = 1'b0;
`endif
    #12 chk("reset", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #8  rst_n = 1'b1;
    #3;

    // mod 14, two periods
    go(4'd14, 8'd2);
    for (int i = 0; i < 28; i++) begin
      chk("m14w2_run", 4'(i % 14), (i % 14) == 13, 8'(i / 14), 1'b1, 1'b0);
      step();
    end
    chk("m14w2_done", 4'd0, 1'b0, 8'd2, 1'b0, 1'b1);
    step();
    chk("m14w2_idle", 4'd0, 1'b0, 8'd2, 1'b0, 1'b0);

    // invalid modulus falls back to 14, free-running until stopped
    go(4'd0, 8'd0);
    for (int i = 0; i < 44; i++) begin
      chk("m0_free", 4'(i % 14), (i % 14) == 13, 8'(i / 14), 1'b1, 1'b0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("m0_stop", 4'd0, 1'b0, 8'd3, 1'b0, 1'b0);

    // pause at 5 for three cycles, then pause on the terminal count
    go(4'd10, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk("pause_pre", 4'(i), 1'b0, 8'd0, 1'b1, 1'b0);
      step();
    end
    chk("pause_at5", 4'd5, 1'b0, 8'd0, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_hold", 4'd5, 1'b0, 8'd0, 1'b1, 1'b0);
    end
    pause = 1'b0;
    step();
    chk("pause_resume", 4'd6, 1'b0, 8'd0, 1'b1, 1'b0);
    step();
    chk("pause_7", 4'd7, 1'b0, 8'd0, 1'b1, 1'b0);
    step();
    chk("pause_8", 4'd8, 1'b0, 8'd0, 1'b1, 1'b0);
    step();
    chk("pause_tc", 4'd9, 1'b1, 8'd0, 1'b1, 1'b0);
    pause = 1'b1;
    step();
    chk("pause_tc_hold", 4'd9, 1'b0, 8'd0, 1'b1, 1'b0);
    pause = 1'b0;
    step();
    chk("pause_done", 4'd0, 1'b0, 8'd1, 1'b0, 1'b1);
    step();
    chk("pause_idle", 4'd0, 1'b0, 8'd1, 1'b0, 1'b0);

    // stop on the last value of the final period; mid-run input changes ignored
    mod_val = 4'd14; wraps = 8'd2; start = 1'b1;
    step();
    mod_val = 4'd3; wraps = 8'd5;
    for (int i = 0; i < 27; i++) begin
      chk("stop_run", 4'(i % 14), (i % 14) == 13, 8'(i / 14), 1'b1, 1'b0);
      step();
    end
    chk("stop_at13", 4'd13, 1'b1, 8'd1, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("stop_idle", 4'd0, 1'b0, 8'd1, 1'b0, 1'b0);
    step();
    chk("stop_nodone", 4'd0, 1'b0, 8'd1, 1'b0, 1'b0);

    // reset mid-run, then an immediate new run
    go(4'd10, 8'd0);
    for (int i = 0; i < 7; i++) begin
      chk("rst_run", 4'(i), 1'b0, 8'd0, 1'b1, 1'b0);
      step();
    end
    chk("rst_at7", 4'd7, 1'b0, 8'd0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 4'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    go(4'd5, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk("rst_m5", 4'(i), i == 4, 8'd0, 1'b1, 1'b0);
      step();
    end
    chk("rst_m5_done", 4'd0, 1'b0, 8'd1, 1'b0, 1'b1);
    step();

    // shortest run: mod 2, one period
    go(4'd2, 8'd1);
    chk("m2w1_q0", 4'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    step();
    chk("m2w1_q1", 4'd1, 1'b1, 8'd0, 1'b1, 1'b0);
    step();
    chk("m2w1_done", 4'd0, 1'b0, 8'd1, 1'b0, 1'b1);
    step();

    // free-running wrap count saturates at 255
    go(4'd2, 8'd0);
    for (int i = 0; i < 520; i++) begin
      chk("sat_run", 4'(i % 2), (i % 2) == 1, (i / 2 > 255) ? 8'd255 : 8'(i / 2), 1'b1, 1'b0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sat_stop", 4'd0, 1'b0, 8'd255, 1'b0, 1'b0);

`ifdef COUNT_DOWN_EN
    dir = 1'b1;
    go(4'd4, 8'd1);
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("down_run", 4'(3 - i), i == 3, 8'd0, 1'b1, 1'b0);
      step();
    end
    chk("down_done", 4'd0, 1'b0, 8'd1, 1'b0, 1'b1);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mod_count_seq.md
MOD_COUNT_SEQ -- requirements
Module: mod_count_seq

Interface
REQ-001 The block SHALL have parameter DEFAULT_MOD, default 14: the modulus used when mod_val is invalid (0 or 1).
REQ-002 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1: begin a counting run; sampled in IDLE only.
REQ-005 The block SHALL have port stop, input, 1: abort the run; highest priority.
REQ-006 The block SHALL have port pause, input, 1: hold count while high.
REQ-007 The block SHALL have port mod_val, input, 4: modulus; count range 0..mod_val-1.
REQ-008 The block SHALL have port wraps, input, 8: full periods per run; 0 means free-running.
REQ-009 The block SHALL have port q, output, 4: current count.
REQ-010 The block SHALL have port tc, output, 1: terminal count, high while q is the last value of the period and the state is RUN.
REQ-011 The block SHALL have port wrap_cnt, output, 8: periods completed in the current run.
REQ-012 The block SHALL have port busy, output, 1: high in RUN or PAUSE.
REQ-013 The block SHALL have port done, output, 1: one-cycle pulse marking run completion.

Function
REQ-014 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE; all outputs are registered or decoded from registers.
REQ-015 In IDLE, a start SHALL latch mod_val and wraps into shadow registers and move to RUN on the next edge, with q=0 and wrap_cnt=0.
REQ-016 An invalid latched mod_val (0 or 1) SHALL be replaced by DEFAULT_MOD.
REQ-017 In RUN, q SHALL increment by 1 per clock; at q==mod-1, the next q is 0 and wrap_cnt increments by 1, saturating at 255 when free-running.
REQ-018 In RUN with wraps!=0, the wrap where wrap_cnt+1==wraps SHALL go to DONE with q=0 and wrap_cnt holding the final count.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE; wrap_cnt clears on the next start.
REQ-020 pause=1 in RUN SHALL go to PAUSE with q, wrap_cnt and tc frozen (tc=0 in PAUSE); pause=0 returns to RUN, and counting resumes on the next edge.
REQ-021 stop=1 in any state SHALL force IDLE on the next edge with q=0; stop overrides pause, start and a same-cycle wrap/DONE (no done pulse).
REQ-022 start while busy or in DONE SHALL be ignored; changes to mod_val or wraps during a run SHALL be ignored.
REQ-023 wraps==1 with mod 2 SHALL give sequence 0,1 then DONE (2 RUN cycles).

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, with q=0, wrap_cnt=0, tc=0, busy=0, done=0, and shadow registers set to mod=DEFAULT_MOD and wraps=0.
REQ-025 Reset mid-run SHALL abandon the run without a done pulse; first start is accepted on the first edge after rst_n rises.

Configuration
REQ-026 With COUNT_DOWN_EN defined, input dir (1 bit) SHALL be added and latched at start; dir=1 counts mod-1 down to 0, reloading mod-1, with tc at q==0 and the first RUN q=mod-1. Without the macro, the port is absent and counting is up only.

Structure
REQ-027 Package mod_seq_pkg SHALL hold the state enum, DEFAULT_MOD default, and the count and wrap width constants (4, 8).
REQ-028 Sub-module mod_counter_core SHALL hold the q register with inputs en, clr, mod and (optionally) dir, and outputs q and wrap; the FSM lives in mod_count_seq.

Verification
REQ-029 Scenario: rst_n low 20 ns, then start with mod_val=14, wraps=2 -> q 0..13,0..13; tc at each 13; wrap_cnt 1 then 2; done one cycle after the 28th RUN cycle; busy low thereafter.
REQ-030 Scenario: start with mod_val=0, wraps=0 -> counts 0..13 repeatedly (DEFAULT_MOD); wrap_cnt increments each 14 cycles; done is never asserted.
REQ-031 Scenario: pause for 3 cycles at q=5 -> q holds at 5 and tc=0; q=6 on the first edge after pause drops.
REQ-032 Scenario: stop asserted at q=13 on the final wrap -> IDLE with q=0 and no done pulse; a start during that cycle is ignored.
REQ-033 Scenario: rst_n pulsed low mid-run at q=7 -> immediate q=0 and busy=0 before the next clock edge; a new start with mod_val=5, wraps=1 gives 0..4 then done.
REQ-034 Scenario: with COUNT_DOWN_EN, dir=1, mod_val=4, wraps=1 -> q 3,2,1,0 with tc at 0, then done.
